// File: rtl/sum_diff_decoder.sv
// sum_diff_decoder: recovers A/B from a sum/difference pair through a 2-stage valid/ready pipeline.
module sum_diff_decoder #(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_valid,
  output logic             OUT_inReady,
  input  logic [N:0]       IN_sum,
  input  logic [N:0]       IN_diff,
  input  logic             IN_parity,
  output logic             OUT_valid,
  input  logic             IN_outReady,
  output logic [N-1:0]     OUT_dataA,
  output logic [N-1:0]     OUT_dataB,
  output logic             OUT_oddErr,
  output logic             OUT_parErr,
  output logic [CNT_W-1:0] OUT_errCnt
);
  logic           v1, v2, p1;
  logic [N+1:0]   t1, u1, s_ext, d_ext;
  logic           in_fire, out_fire, adv;
  assign s_ext       = {1'b0, IN_sum};
  assign d_ext       = {IN_diff[N], IN_diff};
  assign OUT_valid   = v2;
  assign OUT_inReady = !v1 || !v2 || IN_outReady;
  assign in_fire     = IN_valid && OUT_inReady;
  assign out_fire    = v2 && IN_outReady;
  assign adv         = v1 && (!v2 || IN_outReady);
  // An accepted beat with v1 set implies stage 1 is advancing, so v1 stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      p1         <= 1'b0;
      t1         <= '0;
      u1         <= '0;
      OUT_dataA  <= '0;
      OUT_dataB  <= '0;
      OUT_oddErr <= 1'b0;
      OUT_parErr <= 1'b0;
      OUT_errCnt <= '0;
    end else begin
      v1 <= in_fire ? 1'b1 : (adv ? 1'b0 : v1);
      v2 <= adv ? 1'b1 : (out_fire ? 1'b0 : v2);
      if (in_fire) begin
        t1 <= s_ext + d_ext;
        u1 <= s_ext - d_ext;
        p1 <= IN_parity;
      end
      if (adv) begin
        OUT_dataA  <= t1[N:1];
        OUT_dataB  <= u1[N:1];
        OUT_oddErr <= t1[0];
        OUT_parErr <= (^t1[N:1]) ^ p1;
      end
      if (out_fire && (OUT_oddErr || OUT_parErr) && OUT_errCnt != '1)
        OUT_errCnt <= OUT_errCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sum_diff_decoder.sv
// tb_sum_diff_decoder: directed checks of decode, latency, stall, saturation and reset.
module tb_sum_diff_decoder;
  logic       clk = 0, rst = 1;
  logic       IN_valid = 0, IN_parity = 0, IN_outReady = 1;
  logic [8:0] IN_sum = 0, IN_diff = 0;
  logic       OUT_inReady, OUT_valid, OUT_oddErr, OUT_parErr;
  logic [7:0] OUT_dataA, OUT_dataB;
  logic [1:0] OUT_errCnt;
  int         passed = 0, total = 0;
  always #5 clk = ~clk;
  sum_diff_decoder #(.N(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .IN_valid(IN_valid), .OUT_inReady(OUT_inReady),
    .IN_sum(IN_sum), .IN_diff(IN_diff), .IN_parity(IN_parity),
    .OUT_valid(OUT_valid), .IN_outReady(IN_outReady),
    .OUT_dataA(OUT_dataA), .OUT_dataB(OUT_dataB),
    .OUT_oddErr(OUT_oddErr), .OUT_parErr(OUT_parErr), .OUT_errCnt(OUT_errCnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Single beat into an empty pipeline with the sink always ready.
  task automatic beat(input string tag, input logic [8:0] s, input logic [8:0] d, input logic p,
                      input logic [7:0] ea, input logic [7:0] eb, input logic eo, input logic ep,
                      input logic [1:0] ecnt);
    IN_valid = 1; IN_sum = s; IN_diff = d; IN_parity = p; IN_outReady = 1;
    #1 check({tag, "_rdy"}, OUT_inReady, 1);
    tick();
    IN_valid = 0;
    check({tag, "_lat1"}, OUT_valid, 0);
    tick();
    check({tag, "_valid"}, OUT_valid, 1);
    check({tag, "_a"}, OUT_dataA, ea);
    check({tag, "_b"}, OUT_dataB, eb);
    check({tag, "_odd"}, OUT_oddErr, eo);
    check({tag, "_par"}, OUT_parErr, ep);
    tick();
    check({tag, "_drain"}, OUT_valid, 0);
    check({tag, "_cnt"}, OUT_errCnt, ecnt);
  endtask
  initial begin
    logic [7:0] ea[6], eb[6], pa, pb;
    logic       held, acc;
    int         sent, got;
    tick(); tick();
    rst = 0;
    tick();
    check("rst_valid", OUT_valid, 0);
    check("rst_rdy", OUT_inReady, 1);
    check("rst_a", OUT_dataA, 0);
    check("rst_cnt", OUT_errCnt, 0);
    beat("basic", 9'd10, 9'd4, 1, 8'd7, 8'd3, 0, 0, 0);
    beat("carry", 9'h1FE, 9'd0, 0, 8'hFF, 8'hFF, 0, 0, 0);
    beat("negd", 9'd10, 9'h1FC, 0, 8'd3, 8'd7, 0, 0, 0);
    beat("odd", 9'd5, 9'd2, 0, 8'd3, 8'd1, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      ea[i] = 8'(i * 37 + 5);
      eb[i] = 8'(i * 23 + 200);
    end
    sent = 0; got = 0; held = 0; pa = 0; pb = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      IN_outReady = !(c >= 3 && c < 6);
      IN_valid = sent < 6;
      if (sent < 6) begin
        IN_sum = {1'b0, ea[sent]} + {1'b0, eb[sent]};
        IN_diff = {1'b0, ea[sent]} - {1'b0, eb[sent]};
        IN_parity = ^ea[sent];
      end
      #1;
      if (c >= 3 && c < 6) check("strm_stall_rdy", OUT_inReady, 0);
      if (OUT_valid && held) check("strm_hold", {OUT_dataA, OUT_dataB}, {pa, pb});
      if (OUT_valid && IN_outReady && got < 6) begin
        check("strm_a", OUT_dataA, ea[got]);
        check("strm_b", OUT_dataB, eb[got]);
        check("strm_err", {OUT_oddErr, OUT_parErr}, 0);
        got++;
      end
      held = OUT_valid && !IN_outReady;
      pa = OUT_dataA; pb = OUT_dataB;
      acc = IN_valid && OUT_inReady;
      tick();
      if (acc) sent++;
    end
    IN_valid = 0; IN_outReady = 1;
    check("strm_count", got, 6);
    check("strm_cnt", OUT_errCnt, 1);
    rst = 1; tick(); rst = 0; tick();
    for (int i = 0; i < 5; i++)
      beat("sat", 9'd10, 9'd4, 0, 8'd7, 8'd3, 0, 1, (i < 3) ? 2'(i + 1) : 2'd3);
    IN_valid = 1; IN_sum = 9'd10; IN_diff = 9'd4; IN_parity = 1;
    tick(); tick();
    IN_valid = 0; rst = 1;
    tick();
    rst = 0;
    check("mrst_valid", OUT_valid, 0);
    check("mrst_cnt", OUT_errCnt, 0);
    check("mrst_a", OUT_dataA, 0);
    tick();
    check("mrst_rdy", OUT_inReady, 1);
    check("mrst_novalid", OUT_valid, 0);
    beat("post", 9'd10, 9'h1FC, 0, 8'd3, 8'd7, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
